// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, one operand bit per clock.
// Optional subtraction mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the sub port).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             inv_q, inv_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    // Single full-adder cell operating on the current LSBs.
    logic             bit_a, bit_b, bit_s, bit_c;
    logic [WIDTH-1:0] res_shifted;

    always_comb begin
        bit_a = a_sh_q[0];
        bit_b = b_sh_q[0] ^ inv_q;
        bit_s = bit_a ^ bit_b ^ carry_q;
        bit_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
        res_shifted            = res_q >> 1;
        res_shifted[WIDTH-1]   = bit_s;
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        inv_d   = inv_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_ADDER_SUB_EN
                    // Two's-complement subtraction: invert B and force carry-in to 1.
                    inv_d   = sub;
                    carry_d = sub | cin;
`else
                    inv_d   = 1'b0;
                    carry_d = cin;
`endif
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_shifted;
                carry_d = bit_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_shifted;
                    cout_d  = bit_c;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            inv_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            inv_q   <= inv_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake/reset cases
// and a 1-bit instance driven through the full-adder truth table.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8, sub1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_done;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done8) n_done++;
    endtask

    // After an accepted start edge: WIDTH-1 running cycles holding the old result, then completion.
    task automatic finish_op8(input string tag, input logic [7:0] hold_sum,
                              input logic [7:0] exp_sum, input logic exp_cout);
        for (int i = 1; i < 8; i++) begin
            tick();
            check({tag, " run busy"}, 32'(busy8), 32'd1);
            check({tag, " run done"}, 32'(done8), 32'd0);
            check({tag, " run sum hold"}, 32'(sum8), 32'(hold_sum));
        end
        tick();
        check({tag, " done"}, 32'(done8), 32'd1);
        check({tag, " busy at done"}, 32'(busy8), 32'd0);
        check({tag, " sum"}, 32'(sum8), 32'(exp_sum));
        check({tag, " cout"}, 32'(cout8), 32'(exp_cout));
    endtask

    initial begin
        logic [1:0] tot;
        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0; sub1 = 1'b0;
`endif
        n_done = 0;
        tick(); tick();
        check("reset busy", 32'(busy8), 32'd0);
        check("reset done", 32'(done8), 32'd0);
        check("reset sum", 32'(sum8), 32'd0);
        check("reset cout", 32'(cout8), 32'd0);
        check("reset busy w1", 32'(busy1), 32'd0);
        rst = 1'b0;
        tick();

        // 0x3C + 0x5A = 0x96
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("op1 busy after start", 32'(busy8), 32'd1);
        check("op1 done after start", 32'(done8), 32'd0);
        finish_op8("op1", 8'h00, 8'h96, 1'b0);

        // Back-to-back: start raised in the done cycle.
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("op2 accepted in done cycle", 32'(busy8), 32'd1);
        finish_op8("op2", 8'h96, 8'h00, 1'b1);

        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("op3 accepted in done cycle", 32'(busy8), 32'd1);
        finish_op8("op3", 8'h00, 8'hFF, 1'b1);
        tick();

        // start spam while busy with operands changing: 0x12 + 0x34 + 1 = 0x47.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        tick();
        n_done = 0;
        for (int i = 1; i < 8; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~cin8;
            tick();
        end
        start8 = 1'b0;
        tick();
        check("ignore sum", 32'(sum8), 32'h47);
        check("ignore cout", 32'(cout8), 32'd0);
        tick(); tick(); tick();
        check("ignore single done", 32'(n_done), 32'd1);
        check("ignore idle after", 32'(busy8), 32'd0);

        // Reset at E4 of a run abandons it.
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst busy", 32'(busy8), 32'd0);
        check("rst done", 32'(done8), 32'd0);
        check("rst sum", 32'(sum8), 32'd0);
        check("rst cout", 32'(cout8), 32'd0);
        n_done = 0;
        for (int i = 0; i < 10; i++) tick();
        check("rst no done", 32'(n_done), 32'd0);

        // WIDTH=1 exhaustive full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
            tot = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check($sformatf("w1 busy %0d", i), 32'(busy1), 32'd1);
            tick();
            check($sformatf("w1 done %0d", i), 32'(done1), 32'd1);
            check($sformatf("w1 sum %0d", i), 32'(sum1), 32'(tot[0]));
            check($sformatf("w1 cout %0d", i), 32'(cout1), 32'(tot[1]));
        end
        tick();
        check("w1 done single pulse", 32'(done1), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        // 0x05 - 0x07 = 0xFE with borrow; 0x07 - 0x05 = 0x02 without.
        a8 = 8'h05; b8 = 8'h07; cin8 = 1'b0; sub8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0; sub8 = 1'b0;
        finish_op8("sub1", 8'h00, 8'hFE, 1'b0);
        a8 = 8'h07; b8 = 8'h05; sub8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0; sub8 = 1'b0;
        finish_op8("sub2", 8'hFE, 8'h02, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
